// File: rtl/vx_mem_rsp_gather_pkg.sv
// Shared types for the memory response gatherer: per-entry table state
// and the table-depth helper.
package VX_gather_pkg;

  // Lane count the entry_state_t layout is built for; the top's NUM_REQS
  // must equal this so the struct fields line up with the masks.
  localparam int GATHER_NUM_REQS = 4;

  typedef struct packed {
    logic                       busy;
    logic [GATHER_NUM_REQS-1:0] expected;
    logic [GATHER_NUM_REQS-1:0] pending;
  } entry_state_t;

  // Table depth from the number of tag bits used as an index.
  function automatic int num_entries(input int id_width);
    return 1 << id_width;
  endfunction

endpackage

// File: rtl/vx_mem_rsp_gather_out_reg.sv
// One-deep valid/ready register. Holds its payload stable until the
// consumer accepts it, and accepts a new payload in the same cycle the
// old one drains.
module VX_gather_out_reg #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Load on a free or draining slot; otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/vx_mem_rsp_gather.sv
// Gathers partial memory response beats per request into one complete
// response. The low tag bits index a small table tracking which lanes are
// still outstanding; the beat that covers the last pending lanes is merged
// with the stored lanes and pushed to the output register.
module vx_mem_rsp_gather
  import VX_gather_pkg::*;
#(
  parameter int NUM_REQS   = GATHER_NUM_REQS,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_valid,
  input  logic [ID_WIDTH-1:0]            alloc_id,
  input  logic [NUM_REQS-1:0]            alloc_mask,
  output logic                           alloc_ready,
  input  logic                           rsp_valid_in,
  input  logic                           rsp_rw_in,
  input  logic [NUM_REQS-1:0]            rsp_mask_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data_in,
  input  logic [TAG_WIDTH-1:0]           rsp_tag_in,
  output logic                           rsp_ready_in,
  output logic                           rsp_valid_out,
  output logic                           rsp_rw_out,
  output logic [NUM_REQS-1:0]            rsp_mask_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data_out,
  output logic [TAG_WIDTH-1:0]           rsp_tag_out,
  input  logic                           rsp_ready_out
);

  localparam int NUM_ENTRIES = num_entries(ID_WIDTH);
  localparam int DW          = NUM_REQS * DATA_WIDTH;
  localparam int DATAW       = 1 + NUM_REQS + TAG_WIDTH + DW;

  entry_state_t                        ent_q  [NUM_ENTRIES];
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] data_q [NUM_ENTRIES];
  // rw of the first accepted beat, kept only to cross-check later beats.
  logic [NUM_ENTRIES-1:0]              rw_q;

  logic [ID_WIDTH-1:0]                 rsp_id;
  entry_state_t                        cur;
  logic [NUM_REQS-1:0]                 hit;
  logic                                completing;
  logic                                out_free;
  logic                                beat_fire;
  logic                                alloc_fire;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] in_data;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] merged;
  logic [DATAW-1:0]                    out_data;

  assign rsp_id  = rsp_tag_in[ID_WIDTH-1:0];
  assign cur     = ent_q[rsp_id];
  assign in_data = rsp_data_in;

  // Stray lanes (not pending) are masked off here and never stored.
  assign hit        = rsp_mask_in & cur.pending;
  // A FREE entry never completes, so a stray beat to it is just absorbed.
  assign completing = cur.busy && ((cur.pending & ~rsp_mask_in) == '0);
  assign rsp_ready_in = !completing || out_free;
  assign beat_fire    = rsp_valid_in && rsp_ready_in && cur.busy;

  assign alloc_ready = !ent_q[alloc_id].busy;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Completing beat lanes bypass the stored copy.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_merge
    assign merged[i] = hit[i] ? in_data[i] : data_q[rsp_id][i];
  end

  // Entry lifecycle: beat retires lanes or frees the entry; alloc claims it.
  // Both cannot target one entry in a cycle: alloc needs it FREE, a beat
  // needs it busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < NUM_ENTRIES; e++) ent_q[e] <= '0;
      rw_q <= '0;
    end else begin
      if (beat_fire) begin
        if (completing) begin
          ent_q[rsp_id] <= '0;
        end else begin
          ent_q[rsp_id].pending <= cur.pending & ~hit;
          rw_q[rsp_id]          <= rsp_rw_in;
        end
      end
      if (alloc_fire) begin
        ent_q[alloc_id] <= '{busy: 1'b1, expected: alloc_mask, pending: alloc_mask};
      end
    end
  end

  // Partial-beat lane storage; contents are meaningless while FREE.
  always_ff @(posedge clk) begin
    if (beat_fire && !completing) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (hit[i]) data_q[rsp_id][i] <= in_data[i];
      end
    end
  end

  VX_gather_out_reg #(
    .DATAW (DATAW)
  ) u_out (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rsp_valid_in && completing),
    .in_ready  (out_free),
    .in_data   ({rsp_rw_in, cur.expected, rsp_tag_in, merged}),
    .out_valid (rsp_valid_out),
    .out_ready (rsp_ready_out),
    .out_data  (out_data)
  );

  assign rsp_data_out = out_data[DW-1:0];
  assign rsp_tag_out  = out_data[DW +: TAG_WIDTH];
  assign rsp_mask_out = out_data[DW+TAG_WIDTH +: NUM_REQS];
  assign rsp_rw_out   = out_data[DATAW-1];

  // Protocol checks on the issuing side.
  a_alloc_mask: assert property (@(posedge clk) disable iff (!reset)
    alloc_fire |-> alloc_mask != '0);
  a_free_beat: assert property (@(posedge clk) disable iff (!reset)
    rsp_valid_in |-> cur.busy);
  a_stray_lanes: assert property (@(posedge clk) disable iff (!reset)
    rsp_valid_in && cur.busy |-> (rsp_mask_in & ~cur.pending) == '0);
  a_rw_consistent: assert property (@(posedge clk) disable iff (!reset)
    rsp_valid_in && cur.busy && (cur.pending != cur.expected) |-> rsp_rw_in == rw_q[rsp_id]);

endmodule

// File: tb/tb_vx_mem_rsp_gather.sv
// Directed bench with a scoreboard: expected responses are queued when the
// completing beat is issued; a negedge monitor compares each handshake.
module tb_vx_mem_rsp_gather;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         alloc_valid = 1'b0;
  logic [1:0]   alloc_id = '0;
  logic [3:0]   alloc_mask = '0;
  logic         alloc_ready;
  logic         rsp_valid_in = 1'b0;
  logic         rsp_rw_in = 1'b0;
  logic [3:0]   rsp_mask_in = '0;
  logic [127:0] rsp_data_in = '0;
  logic [7:0]   rsp_tag_in = '0;
  logic         rsp_ready_in;
  logic         rsp_valid_out;
  logic         rsp_rw_out;
  logic [3:0]   rsp_mask_out;
  logic [127:0] rsp_data_out;
  logic [7:0]   rsp_tag_out;
  logic         rsp_ready_out = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         rw;
    logic [3:0]   mask;
    logic [7:0]   tag;
    logic [127:0] data;
  } exp_t;
  exp_t exp_q[$];

  vx_mem_rsp_gather dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_id(alloc_id), .alloc_mask(alloc_mask),
    .alloc_ready(alloc_ready),
    .rsp_valid_in(rsp_valid_in), .rsp_rw_in(rsp_rw_in), .rsp_mask_in(rsp_mask_in),
    .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_rw_out(rsp_rw_out), .rsp_mask_out(rsp_mask_out),
    .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pk(input logic [31:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [31:0] lv(input int id, input int lane);
    return 32'hA000_0000 | 32'(id << 8) | 32'(lane);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rw, input logic [3:0] mask, input logic [7:0] tag,
                      input logic [127:0] data);
    exp_t e;
    e.rw = rw; e.mask = mask; e.tag = tag; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic alloc(input logic [1:0] id, input logic [3:0] mask);
    alloc_valid = 1'b1; alloc_id = id; alloc_mask = mask;
    #1;
    chk("alloc_ready_free", 128'(alloc_ready), 128'(1'b1));
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] tag, input logic [3:0] mask,
                      input logic [127:0] data, input logic rw);
    int n = 0;
    rsp_valid_in = 1'b1; rsp_tag_in = tag; rsp_mask_in = mask;
    rsp_data_in = data; rsp_rw_in = rw;
    #1;
    while (!rsp_ready_in && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL beat_timeout tag=%h ready=%0b exp=1", tag, rsp_ready_in);
    end
    step();
    rsp_valid_in = 1'b0;
  endtask

  // Scoreboard monitor: one comparison per output handshake.
  always @(negedge clk) begin
    if (reset && rsp_valid_out && rsp_ready_out) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output tag=%h data=%h exp=none", rsp_tag_out, rsp_data_out);
      end else begin
        exp_t e;
        logic [127:0] dm;
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) dm[i*32 +: 32] = {32{e.mask[i]}};
        if ({rsp_rw_out, rsp_mask_out, rsp_tag_out} !== {e.rw, e.mask, e.tag} ||
            (rsp_data_out & dm) !== (e.data & dm)) begin
          bad++;
          $display("FAIL output rw/mask/tag/data act=%0b/%b/%h/%h exp=%0b/%b/%h/%h",
                   rsp_rw_out, rsp_mask_out, rsp_tag_out, rsp_data_out & dm,
                   e.rw, e.mask, e.tag, e.data & dm);
        end
      end
    end
  end

  initial begin
    logic [127:0] d;
    int ids[8], lanes[8];
    int n;

    // Reset state
    #2;
    chk("rst_valid_out", 128'(rsp_valid_out), 128'(0));
    chk("rst_payload", {rsp_data_out[119:0], rsp_tag_out}, 128'(0));
    chk("rst_mask_rw", 128'({rsp_rw_out, rsp_mask_out}), 128'(0));
    chk("rst_alloc_ready", 128'(alloc_ready), 128'(1));
    chk("rst_rsp_ready_in", 128'(rsp_ready_in), 128'(1));
    step();
    reset = 1'b1;
    step();

    // Single beat
    alloc(2'd1, 4'b1111);
    alloc_id = 2'd1; #1;
    chk("single_busy", 128'(alloc_ready), 128'(0));
    d = pk(32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000);
    push(1'b0, 4'b1111, 8'h41, d);
    beat(8'h41, 4'b1111, d, 1'b0);
    chk("single_valid_next", 128'(rsp_valid_out), 128'(1));
    chk("single_freed", 128'(alloc_ready), 128'(1));
    step();

    // Split request with stray data in unmasked lanes
    alloc(2'd2, 4'b1011);
    beat(8'h82, 4'b0011, pk(32'hDEAD_0003, 32'hBAD0_0002, 32'hA1A1_A1A1, 32'hA0A0_A0A0), 1'b1);
    chk("split_no_early_out", 128'(rsp_valid_out), 128'(0));
    push(1'b1, 4'b1011, 8'hC2, pk(32'hA3A3_A3A3, 32'h0, 32'hA1A1_A1A1, 32'hA0A0_A0A0));
    beat(8'hC2, 4'b1000, pk(32'hA3A3_A3A3, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777), 1'b1);
    chk("split_valid_next", 128'(rsp_valid_out), 128'(1));
    step();

    // Backpressure
    rsp_ready_out = 1'b0;
    alloc(2'd0, 4'b0001);
    alloc(2'd1, 4'b0001);
    alloc(2'd3, 4'b0011);
    push(1'b0, 4'b0001, 8'h01, pk(0, 0, 0, 32'h0000_B001));
    beat(8'h01, 4'b0001, pk(0, 0, 0, 32'h0000_B001), 1'b0);
    rsp_valid_in = 1'b1; rsp_tag_in = 8'h10; rsp_mask_in = 4'b0001;
    rsp_data_in = pk(0, 0, 0, 32'h0000_B000); rsp_rw_in = 1'b0;
    #1;
    chk("bp_stall", 128'(rsp_ready_in), 128'(0));
    step();
    chk("bp_hold", 128'({rsp_valid_out, rsp_tag_out}), 128'({1'b1, 8'h01}));
    rsp_tag_in = 8'h23; rsp_data_in = pk(0, 0, 0, 32'h0000_B030);
    #1;
    chk("bp_partial_ok", 128'(rsp_ready_in), 128'(1));
    step();
    rsp_tag_in = 8'h10; rsp_data_in = pk(0, 0, 0, 32'h0000_B000);
    #1;
    chk("bp_stall_again", 128'(rsp_ready_in), 128'(0));
    rsp_ready_out = 1'b1;
    #1;
    chk("bp_release", 128'(rsp_ready_in), 128'(1));
    push(1'b0, 4'b0001, 8'h10, pk(0, 0, 0, 32'h0000_B000));
    step();
    rsp_valid_in = 1'b0;
    push(1'b0, 4'b0011, 8'h63, pk(0, 0, 32'h0000_B031, 32'h0000_B030));
    beat(8'h63, 4'b0010, pk(0, 0, 32'h0000_B031, 32'hFFFF_FFFF), 1'b0);

    // Reuse: completion and alloc on one id in the same cycle
    alloc(2'd0, 4'b1111);
    d = pk(32'hC3, 32'hC2, 32'hC1, 32'hC0);
    rsp_valid_in = 1'b1; rsp_tag_in = 8'h04; rsp_mask_in = 4'b1111;
    rsp_data_in = d; rsp_rw_in = 1'b0;
    alloc_valid = 1'b1; alloc_id = 2'd0; alloc_mask = 4'b0110;
    #1;
    chk("reuse_same_cycle", 128'(alloc_ready), 128'(0));
    chk("reuse_beat_ready", 128'(rsp_ready_in), 128'(1));
    push(1'b0, 4'b1111, 8'h04, d);
    step();
    rsp_valid_in = 1'b0;
    #1;
    chk("reuse_next_cycle", 128'(alloc_ready), 128'(1));
    step();
    alloc_valid = 1'b0;
    #1;
    chk("reuse_taken", 128'(alloc_ready), 128'(0));
    push(1'b0, 4'b0110, 8'h08, pk(0, 32'hE2, 32'hE1, 0));
    beat(8'h08, 4'b0110, pk(32'hFFFF_FFFF, 32'hE2, 32'hE1, 32'hFFFF_FFFF), 1'b0);

    // Interleave out of order, back-to-back
    for (int i = 0; i < 4; i++) alloc(2'(i), 4'b0101);
    ids   = '{2, 0, 3, 1, 0, 3, 1, 2};
    lanes = '{0, 2, 0, 0, 0, 2, 2, 2};
    for (int k = 0; k < 8; k++) begin
      d = {4{32'hFFFF_FFFF}};
      d[lanes[k]*32 +: 32] = lv(ids[k], lanes[k]);
      if (k >= 4)
        push(ids[k] == 1, 4'b0101, 8'h90 + 8'(ids[k]),
             pk(0, lv(ids[k], 2), 0, lv(ids[k], 0)));
      beat((k >= 4 ? 8'h90 : 8'h50) + 8'(ids[k]), 4'b0001 << lanes[k], d, ids[k] == 1);
    end
    step();

    // Async reset mid-request
    alloc(2'd2, 4'b1111);
    beat(8'h02, 4'b0011, pk(0, 0, 32'h2222_0001, 32'h2222_0000), 1'b0);
    rsp_ready_out = 1'b0;
    alloc(2'd1, 4'b0001);
    beat(8'h01, 4'b0001, pk(0, 0, 0, 32'h1234_5678), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("ar_valid_out", 128'(rsp_valid_out), 128'(0));
    chk("ar_payload", {rsp_data_out[119:0], rsp_tag_out}, 128'(0));
    chk("ar_mask_rw", 128'({rsp_rw_out, rsp_mask_out}), 128'(0));
    alloc_id = 2'd2; #1;
    chk("ar_alloc_ready", 128'(alloc_ready), 128'(1));
    chk("ar_rsp_ready_in", 128'(rsp_ready_in), 128'(1));
    step();
    reset = 1'b1;
    rsp_ready_out = 1'b1;
    step();
    chk("ar_still_idle", 128'(rsp_valid_out), 128'(0));
    alloc(2'd2, 4'b0011);
    push(1'b0, 4'b0011, 8'h72, pk(0, 0, 32'h7272_0001, 32'h7272_0000));
    beat(8'h72, 4'b0011, pk(0, 0, 32'h7272_0001, 32'h7272_0000), 1'b0);

    // Drain scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
